saradc_sample_fifo: RTL

Downstream consumer of the SAR ADC macro in the user project: drives the ADC's `en`/`cal` controls, captures each conversion when `valid` rises, optionally averages 2^k consecutive 10-bit results, and buffers them in a FIFO that firmware reads over the Caravel Wishbone slave port. It also raises a user IRQ when the buffered sample count reaches a programmable threshold, or when samples have been lost.

---
 rtl/saradc_sample_fifo_if.sv | 32 +++
 rtl/saradc_sample_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/saradc_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// saradc_sample_fifo_if
//   Wishbone classic slave bus as seen by saradc_sample_fifo. Signal names keep
//   the Caravel wbs_* naming so the wrapper can wire them straight through.
//
//   wbs_cyc_i, wbs_stb_i, wbs_we_i : cycle controls (master -> slave)
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_sel_i [3:0]                : byte lanes
//   wbs_ack_o                      : acknowledge (slave -> master)
//   wbs_dat_o [31:0]               : read data (slave -> master)
// -----------------------------------------------------------------------------
interface saradc_sample_fifo_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/saradc_sample_fifo.sv
// -----------------------------------------------------------------------------
// saradc_sample_fifo
//   Drives the SAR ADC en/cal controls, captures each conversion on the rising
//   edge of adc_valid, optionally averages 2^k results, and buffers them in a
//   FIFO readable over Wishbone. Raises irq on a count threshold or on loss.
//
//   wb_clk_i, wb_rst_i  : clock, synchronous active-high reset
//   adc_valid           : ADC conversion-done level
//   adc_result [9:0]    : ADC conversion code
//   adc_en, adc_cal     : ADC controls (CTRL.en / CTRL.cal)
//   wbs                 : Wishbone slave bus (saradc_sample_fifo_if.slave)
//   irq                 : registered level interrupt
//
//   Register map (offset from BASE_ADR):
//     0x0 CTRL   [0] en [1] cal [4:2] avg_log2 [8] clr (W1 pulse) [9] irq_en
//     0x4 STATUS [6:0] count [8] empty [9] full [10] ovf (W1C)
//     0x8 DATA   read pops; 32'h8000_0000 when empty
//     0xC THRESH [6:0] irq threshold, 0 = disabled
// -----------------------------------------------------------------------------
module saradc_sample_fifo #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DEPTH    = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 adc_valid,
  input  logic [9:0]           adc_result,
  output logic                 adc_en,
  output logic                 adc_cal,
  saradc_sample_fifo_if.slave  wbs,
  output logic                 irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Register state
  logic          en_q, en_d, cal_q, cal_d, irq_en_q, irq_en_d;
  logic [2:0]    k_q, k_d;
  logic [6:0]    thresh_q, thresh_d;
  logic          ovf_q, ovf_d;
  logic          prev_valid_q;
  logic [13:0]   acc_q, acc_d;
  logic [4:0]    n_q, n_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          irq_q, irq_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]    mem_q [DEPTH];

  // Decode and status
  logic          hit, wr, rd;
  logic [1:0]    off;
  logic [PW-1:0] count;
  logic [6:0]    count7;
  logic          empty, full;
  logic [2:0]    k_wr;
  logic          ctrl_wr_lo, ctrl_wr_hi, clr, k_chg, en_off;
  logic          accept, avg_done, push_req, push, pop, drop;
  logic [13:0]   sum;
  logic [9:0]    push_data;
  logic [31:0]   rdata;

  // A held strobe gets no hit on the cycle after an ack, giving one ack per two cycles.
  assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
               (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr  = hit & wbs.wbs_we_i;
  assign rd  = hit & ~wbs.wbs_we_i;
  assign off = wbs.wbs_adr_i[3:2];

  assign count  = wr_ptr_q - rd_ptr_q;
  assign count7 = 7'(count);
  assign empty  = (count == '0);
  assign full   = (count == PW'(DEPTH));

  // Out-of-range averaging exponents saturate to 4 (16 samples).
  assign k_wr       = (wbs.wbs_dat_i[4:2] > 3'd4) ? 3'd4 : wbs.wbs_dat_i[4:2];
  assign ctrl_wr_lo = wr & (off == 2'd0) & wbs.wbs_sel_i[0];
  assign ctrl_wr_hi = wr & (off == 2'd0) & wbs.wbs_sel_i[1];
  assign clr        = ctrl_wr_hi & wbs.wbs_dat_i[8];
  assign k_chg      = ctrl_wr_lo & (k_wr != k_q);
  assign en_off     = ~en_q | (ctrl_wr_lo & ~wbs.wbs_dat_i[0]);

  assign accept    = adc_valid & ~prev_valid_q & en_q;
  assign sum       = acc_q + {4'b0, adc_result};
  assign avg_done  = ((n_q + 5'd1) == (5'd1 << k_q));
  assign push_data = 10'(sum >> k_q);
  assign push_req  = accept & avg_done;
  assign pop       = rd & (off == 2'd2) & ~empty;
  // A simultaneous pop frees a slot, so a push while full only drops without one.
  assign push      = push_req & ~clr & (~full | pop);
  assign drop      = push_req & ~clr & full & ~pop;

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = {22'b0, irq_en_q, 1'b0, 3'b0, k_q, cal_q, en_q};
      2'd1: rdata = {21'b0, ovf_q, full, empty, 1'b0, count7};
      2'd2: rdata = empty ? 32'h8000_0000 : {22'b0, mem_q[rd_ptr_q[AW-1:0]]};
      default: rdata = {25'b0, thresh_q};
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    en_d     = en_q;
    cal_d    = cal_q;
    k_d      = k_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    n_d      = n_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ack_d    = hit;
    dat_d    = hit ? rdata : 32'h0;

    if (ctrl_wr_lo) begin
      en_d  = wbs.wbs_dat_i[0];
      cal_d = wbs.wbs_dat_i[1];
      k_d   = k_wr;
    end
    if (ctrl_wr_hi) irq_en_d = wbs.wbs_dat_i[9];
    if (wr && off == 2'd3 && wbs.wbs_sel_i[0]) thresh_d = wbs.wbs_dat_i[6:0];

    // A new loss event outranks a same-cycle write-1-to-clear.
    if (drop) ovf_d = 1'b1;
    else if (wr && off == 2'd1 && wbs.wbs_sel_i[1] && wbs.wbs_dat_i[10]) ovf_d = 1'b0;

    if (accept) begin
      if (avg_done) begin
        acc_d = '0;
        n_d   = '0;
      end else begin
        acc_d = sum;
        n_d   = n_q + 5'd1;
      end
    end
    if (clr || k_chg || en_off) begin
      acc_d = '0;
      n_d   = '0;
    end

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    irq_d = irq_en_q & (((thresh_q != 7'd0) && (count7 >= thresh_q)) | ovf_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q         <= 1'b0;
      cal_q        <= 1'b0;
      k_q          <= '0;
      irq_en_q     <= 1'b0;
      thresh_q     <= '0;
      ovf_q        <= 1'b0;
      prev_valid_q <= 1'b0;
      acc_q        <= '0;
      n_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      cal_q        <= cal_d;
      k_q          <= k_d;
      irq_en_q     <= irq_en_d;
      thresh_q     <= thresh_d;
      ovf_q        <= ovf_d;
      prev_valid_q <= adc_valid;
      acc_q        <= acc_d;
      n_q          <= n_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      irq_q        <= irq_d;
    end
  end

  // NOTE: the sample array has no reset; the pointers define which entries
  // are valid, so resetting storage would only add reset fan-out.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign adc_en        = en_q;
  assign adc_cal       = cal_q;
  assign irq           = irq_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

endmodule
